// File: rtl/ycbcr422_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr422_line_sequencer
// Description : Line framing front end for a YCbCr422->444 converter: restarts
//               the chroma phase per line, pads odd lines, appends flush cycles,
//               latches chroma order per frame and flags line-length errors.
//               Build option SEQ_LINE_STATS_EN adds line count / last length.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr422_line_sequencer #(
    parameter int         PIX_W     = 12,
    parameter int         FLUSH_CYC = 2,
    parameter logic [7:0] PAD_Y     = 8'h10,
    parameter logic [7:0] PAD_C     = 8'h80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_cr_first,
    input  logic [PIX_W-1:0] cfg_h_active,
    input  logic             err_clr,
    input  logic             i_v_sync,
    input  logic             i_h_sync,
    input  logic             i_de,
    input  logic [7:0]       i_c,
    input  logic [7:0]       i_y,
    output logic             o_v_sync,
    output logic             o_h_sync,
    output logic             o_conv_de,
    output logic [7:0]       o_conv_c,
    output logic [7:0]       o_conv_y,
    output logic             o_phase_rst,
    output logic             o_cr_first,
    output logic             o_busy,
    output logic             o_err_len,
    output logic             o_err_odd,
    output logic             o_err_gap,
    output logic [PIX_W-1:0] o_line_cnt,
    output logic [PIX_W-1:0] o_last_len
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_PAD    = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [2:0]       FLUSH_LAST = 3'(FLUSH_CYC - 1);
    localparam logic [PIX_W-1:0] PIX_ONE    = PIX_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       flush_q, flush_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             line_end, gap_evt, odd_evt;

    logic             v_sync_q, h_sync_q;
    logic             conv_de_q, phase_rst_q, cr_first_q;
    logic [7:0]       conv_c_q, conv_y_q;
    logic             err_len_q, err_odd_q, err_gap_q;
    logic             frame_start;

    assign frame_start = i_v_sync & ~v_sync_q;

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        pix_d    = pix_q;
        line_end = 1'b0;
        gap_evt  = 1'b0;
        odd_evt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_de) begin
                    state_d = S_ACTIVE;
                    pix_d   = PIX_ONE;
                end
            end
            S_ACTIVE: begin
                if (i_de) begin
                    if (pix_q != {PIX_W{1'b1}}) pix_d = pix_q + PIX_ONE;
                end else begin
                    line_end = 1'b1;
                    state_d  = pix_q[0] ? S_PAD : S_FLUSH;
                    flush_d  = FLUSH_LAST;
                end
            end
            S_PAD: begin
                odd_evt = 1'b1;
                if (i_de) begin
                    gap_evt = 1'b1;
                    state_d = S_ACTIVE;
                    pix_d   = PIX_ONE;
                end else begin
                    state_d = S_FLUSH;
                    flush_d = FLUSH_LAST;
                end
            end
            S_FLUSH: begin
                if (i_de) begin
                    gap_evt = 1'b1;
                    state_d = S_ACTIVE;
                    pix_d   = PIX_ONE;
                end else if (flush_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = flush_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers follow the next state so data latency stays at one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flush_q     <= 3'd0;
            pix_q       <= '0;
            v_sync_q    <= 1'b0;
            h_sync_q    <= 1'b0;
            conv_de_q   <= 1'b0;
            conv_c_q    <= 8'd0;
            conv_y_q    <= 8'd0;
            phase_rst_q <= 1'b0;
            cr_first_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_odd_q   <= 1'b0;
            err_gap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            pix_q       <= pix_d;
            v_sync_q    <= i_v_sync;
            h_sync_q    <= i_h_sync;
            conv_de_q   <= (state_d != S_IDLE);
            conv_c_q    <= (state_d == S_ACTIVE) ? i_c : PAD_C;
            conv_y_q    <= (state_d == S_ACTIVE) ? i_y : PAD_Y;
            phase_rst_q <= (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
            if (frame_start) cr_first_q <= cfg_cr_first;
            err_len_q   <= (line_end && (pix_q != cfg_h_active)) | (err_len_q & ~err_clr);
            err_odd_q   <= odd_evt | (err_odd_q & ~err_clr);
            err_gap_q   <= gap_evt | (err_gap_q & ~err_clr);
        end
    end

`ifdef SEQ_LINE_STATS_EN
    logic [PIX_W-1:0] line_cnt_q, last_len_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            last_len_q <= '0;
        end else begin
            if (line_end) last_len_q <= pix_q;
            if (frame_start)   line_cnt_q <= '0;
            else if (line_end) line_cnt_q <= line_cnt_q + PIX_ONE;
        end
    end

    assign o_line_cnt = line_cnt_q;
    assign o_last_len = last_len_q;
`else
    assign o_line_cnt = '0;
    assign o_last_len = '0;
`endif

    assign o_v_sync    = v_sync_q;
    assign o_h_sync    = h_sync_q;
    assign o_conv_de   = conv_de_q;
    assign o_conv_c    = conv_c_q;
    assign o_conv_y    = conv_y_q;
    assign o_phase_rst = phase_rst_q;
    assign o_cr_first  = cr_first_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_err_len   = err_len_q;
    assign o_err_odd   = err_odd_q;
    assign o_err_gap   = err_gap_q;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr422_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr422_line_sequencer
// Description : Directed self-checking bench for ycbcr422_line_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr422_line_sequencer;

`ifdef SEQ_LINE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, cfg_cr_first, err_clr;
    logic [11:0] cfg_h_active;
    logic        i_v_sync, i_h_sync, i_de;
    logic [7:0]  i_c, i_y;
    logic        o_v_sync, o_h_sync, o_conv_de, o_phase_rst, o_cr_first, o_busy;
    logic [7:0]  o_conv_c, o_conv_y;
    logic        o_err_len, o_err_odd, o_err_gap;
    logic [11:0] o_line_cnt, o_last_len;

    int n_chk  = 0;
    int n_fail = 0;
    int de_total = 0;
    int prst_total = 0;
    int de0, p0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        de_total   <= de_total + int'(o_conv_de);
        prst_total <= prst_total + int'(o_phase_rst);
    end

    ycbcr422_line_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_cr_first(cfg_cr_first), .cfg_h_active(cfg_h_active),
        .err_clr(err_clr), .i_v_sync(i_v_sync), .i_h_sync(i_h_sync), .i_de(i_de),
        .i_c(i_c), .i_y(i_y), .o_v_sync(o_v_sync), .o_h_sync(o_h_sync),
        .o_conv_de(o_conv_de), .o_conv_c(o_conv_c), .o_conv_y(o_conv_y),
        .o_phase_rst(o_phase_rst), .o_cr_first(o_cr_first), .o_busy(o_busy),
        .o_err_len(o_err_len), .o_err_odd(o_err_odd), .o_err_gap(o_err_gap),
        .o_line_cnt(o_line_cnt), .o_last_len(o_last_len)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pixels(input int n);
        for (int k = 0; k < n; k++) begin
            i_de = 1'b1;
            i_c  = 8'(k);
            i_y  = ~8'(k);
            tick();
        end
        i_de = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_cr_first = 1'b0; err_clr = 1'b0; cfg_h_active = 12'd640;
        i_v_sync = 1'b0; i_h_sync = 1'b1; i_de = 1'b0; i_c = 8'h55; i_y = 8'hAA;

        // Reset with DE toggling: every output must be zero
        for (int k = 0; k < 3; k++) begin
            i_de = ~i_de;
            tick();
            check("reset_outputs",
                  {o_v_sync, o_h_sync, o_conv_de, o_conv_c, o_conv_y, o_phase_rst, o_cr_first,
                   o_busy, o_err_len, o_err_odd, o_err_gap, o_line_cnt, o_last_len}, 64'd0);
        end
        rst_n = 1'b1; i_de = 1'b0;
        tick();
        check("idle_pad_c", o_conv_c, 8'h80);
        check("idle_pad_y", o_conv_y, 8'h10);
        check("h_sync_delay", o_h_sync, 1'b1);
        i_h_sync = 1'b0;
        tick();

        // 640-pixel line, even length
        de0 = de_total; p0 = prst_total;
        i_de = 1'b1; i_c = 8'h00; i_y = 8'hFF;
        tick();
        check("l640_phase_rst", o_phase_rst, 1'b1);
        check("l640_first_c", o_conv_c, 8'h00);
        check("l640_first_y", o_conv_y, 8'hFF);
        check("l640_busy", o_busy, 1'b1);
        i_c = 8'h01; i_y = 8'hFE;
        tick();
        check("l640_phase_rst_low", o_phase_rst, 1'b0);
        check("l640_second_c", o_conv_c, 8'h01);
        for (int k = 2; k < 640; k++) begin
            i_c = 8'(k); i_y = ~8'(k);
            tick();
        end
        check("l640_last_c", o_conv_c, 8'h7F);
        i_de = 1'b0;
        tick();
        check("l640_flush1_de", o_conv_de, 1'b1);
        check("l640_flush1_cy", {o_conv_c, o_conv_y}, 16'h8010);
        tick();
        check("l640_flush2_de", o_conv_de, 1'b1);
        check("l640_flush2_cy", {o_conv_c, o_conv_y}, 16'h8010);
        tick();
        check("l640_de_end", o_conv_de, 1'b0);
        check("l640_busy_end", o_busy, 1'b0);
        tick(); tick();
        check("l640_de_count", de_total - de0, 642);
        check("l640_prst_count", prst_total - p0, 1);
        check("l640_errors", {o_err_len, o_err_odd, o_err_gap}, 3'b000);
        check("l640_last_len", o_last_len, 12'(STATS * 640));

        // 639-pixel line: one pad cycle then flush
        de0 = de_total;
        drive_pixels(639);
        tick();
        check("l639_pad_de", o_conv_de, 1'b1);
        check("l639_pad_cy", {o_conv_c, o_conv_y}, 16'h8010);
        tick(); tick(); tick(); tick(); tick();
        check("l639_de_count", de_total - de0, 642);
        check("l639_err_odd", o_err_odd, 1'b1);
        check("l639_err_len", o_err_len, 1'b1);
        check("l639_err_gap", o_err_gap, 1'b0);
        check("l639_last_len", o_last_len, 12'(STATS * 639));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {o_err_len, o_err_odd}, 2'b00);

        // Two 640-pixel lines with one idle cycle between: flush aborted
        de0 = de_total; p0 = prst_total;
        drive_pixels(640);
        tick();
        check("gap_flush_cy", {o_conv_de, o_conv_c, o_conv_y}, 17'h18010);
        check("gap_err_before", o_err_gap, 1'b0);
        i_de = 1'b1; i_c = 8'h3C; i_y = 8'hC3;
        tick();
        check("gap_phase_rst", o_phase_rst, 1'b1);
        check("gap_err_gap", o_err_gap, 1'b1);
        check("gap_data", {o_conv_c, o_conv_y}, 16'h3CC3);
        drive_pixels(639);
        tick(); tick(); tick(); tick(); tick();
        check("gap_de_count", de_total - de0, 1283);
        check("gap_prst_count", prst_total - p0, 2);
        check("gap_err_len", o_err_len, 1'b0);
        check("gap_err_odd", o_err_odd, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("gap_err_clr", o_err_gap, 1'b0);

        // Chroma order and line count across a frame start
        check("lines_before_vs", o_line_cnt, 12'(STATS * 4));
        cfg_cr_first = 1'b1;
        tick(); tick();
        check("cr_first_midframe", o_cr_first, 1'b0);
        i_v_sync = 1'b1;
        tick();
        check("v_sync_delay", o_v_sync, 1'b1);
        check("cr_first_latched", o_cr_first, 1'b1);
        check("line_cnt_cleared", o_line_cnt, 12'd0);
        cfg_cr_first = 1'b0;
        tick();
        i_v_sync = 1'b0;
        tick();
        check("cr_first_held", o_cr_first, 1'b1);
        cfg_h_active = 12'd4;
        for (int l = 0; l < 3; l++) begin
            drive_pixels(4);
            for (int k = 0; k < 5; k++) tick();
        end
        check("line_cnt_3", o_line_cnt, 12'(STATS * 3));
        check("last_len_4", o_last_len, 12'(STATS * 4));
        check("short_errors", {o_err_len, o_err_odd, o_err_gap}, 3'b000);

        // Reset in the middle of a line
        cfg_h_active = 12'd640;
        for (int k = 0; k < 100; k++) begin
            i_de = 1'b1; i_c = 8'(k); i_y = 8'(k);
            tick();
        end
        check("midline_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midline_rst_de", o_conv_de, 1'b0);
        check("midline_rst_busy", o_busy, 1'b0);
        check("midline_rst_cr", o_cr_first, 1'b0);
        rst_n = 1'b1; i_de = 1'b0;
        tick();
        check("post_rst_idle", {o_conv_de, o_busy}, 2'b00);
        i_de = 1'b1; i_c = 8'hA5; i_y = 8'h5A;
        tick();
        check("post_rst_phase", o_phase_rst, 1'b1);
        check("post_rst_data", {o_conv_c, o_conv_y}, 16'hA55A);
        i_de = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
